rv32m_mul_iter: RTL and testbench
=================================

Name: rv32m_mul_iter

Overview:
Parametrised iterative multiplier for the RV32M execution stage. It covers MUL, MULH, MULHSU and MULHU with an internal controller FSM and valid/ready handshakes on both sides. Operand B is consumed SLICE_W bits per cycle, so latency is XLEN/SLICE_W cycles, trading area against speed. It sits between the decode/issue stage and writeback, and replaces the externally sequenced multiplier datapath.

Parameters:
XLEN, 32, operand and result width; must be a multiple of SLICE_W.
SLICE_W, 8, bits of B consumed per cycle; legal values are 1, 2, 4, 8, 16, 32. Defines N = XLEN/SLICE_W.

Ports:
clk_i  in  1  clock; all state changes on rising edge.
rst_i  in  1  reset, asynchronous, active-high.
valid_i  in  1  request valid.
ready_o  out  1  block can accept a request.
op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
op_A_i  in  XLEN  multiplicand (rs1).
op_B_i  in  XLEN  multiplier (rs2).
kill_i  in  1  abort the current operation (pipeline flush).
valid_o  out  1  result valid.
ready_i  in  1  consumer accepts the result.
result_o  out  XLEN  product, low or high half selected by op.
busy_o  out  1  state is not IDLE.

Behaviour:
- States: IDLE, CALC, DONE. Reset puts the FSM in IDLE, accumulator to 0, cnt to 0, result_o 0, valid_o 0, ready_o 1, busy_o 0.
- IDLE:
  - ready_o = 1.
  - On valid_i & ready_o: register A, B and op; set acc = 0 and cnt = 0; go to CALC.
  - A is signed for MULH and MULHSU. B is signed for MULH only.
- CALC, one step per cycle:
  - Digit d = Breg[SLICE_W-1:0]. d is unsigned, except on the final step (cnt == N-1) when B is signed, where d is signed.
  - Partial product = ext(A, XLEN+1) × ext(d, SLICE_W+1), sign-extended to 2·XLEN and weighted by 2^(cnt·SLICE_W).
  - acc += partial product, mod 2^(2·XLEN).
  - Breg shifts right by SLICE_W, arithmetic if B is signed. cnt increments.
  - When cnt == N-1, go to DONE.
- DONE:
  - valid_o = 1.
  - result_o = acc[XLEN-1:0] for MUL, otherwise acc[2XLEN-1:XLEN].
  - result_o stays stable while ready_i = 0.
  - On ready_i, go to IDLE. ready_o goes high the next cycle; there is no same-cycle re-accept.
- Latency: the accept edge is followed by N CALC edges, and valid_o is high in the cycle after the Nth CALC edge. Throughput is at most one operation per N+2 cycles.
- kill_i:
  - In any state, the next state is IDLE and valid_o drops next cycle. The accumulator is not cleared.
  - kill_i in IDLE together with valid_i: the request is not accepted.
  - kill_i has priority over ready_i.
- Operand inputs are ignored outside the accept cycle.
- Reset mid-operation: immediate return to reset values, with no result emitted.
- busy_o = (state != IDLE).

Optional Feature:
Macro RV32M_MUL_EARLY_EXIT_EN.
- Defined: in CALC, if the shifted remaining Breg (after this step's shift) is all zeros, go to DONE on this edge regardless of cnt. A remaining value of -1 for signed B does not trigger the exit. Latency becomes data dependent: 1..N CALC cycles.
- Undefined: always N CALC cycles.
- Results are identical in both cases.

Decomposition:
- Package rv32m_mul_pkg holds:
  - op encodings (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU);
  - the state encoding (S_IDLE, S_CALC, S_DONE);
  - the signedness decode function.
- One combinational sub-module, rv32m_mul_pp, computes the (XLEN+1)×(SLICE_W+1) signed partial product. It is parametrised by XLEN and SLICE_W.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
1. Default parameters, MUL with A = 7, B = 6, ready_i = 1 → valid_o high 4 cycles after accept, result_o = 0x0000002A.
2. MULH, MULHU and MULHSU with A = B = 0xFFFFFFFF → 0x00000000, 0xFFFFFFFE and 0xFFFFFFFF respectively. MULH with 0x80000000 × 0x80000000 → 0x40000000.
3. Backpressure: complete MUL 0x12345678 × 0x10 while holding ready_i = 0 for 5 cycles → result_o = 0x23456780 held stable, ready_o = 0, and a valid_i offered meanwhile is not accepted.
4. Assert kill_i in the second CALC cycle → IDLE next cycle, no valid_o. A following MUL 3 × 5 returns 0x0000000F.
5. Assert rst_i mid-CALC → all outputs at reset values immediately (async), with ready_o = 1 after release.
6. With SLICE_W = 1 and RV32M_MUL_EARLY_EXIT_EN defined: MUL 9 × 3 → valid_o after 2 CALC cycles, result 0x0000001B. MULH −1 × −1 → full 32 cycles, result 0x00000000.

Source files
------------

// File: rtl/rv32m_mul_pkg.sv
// rv32m_mul_pkg -- shared definitions for the RV32M iterative multiplier.
//   - mul_op_e    : funct3[1:0] operation encodings (MUL, MULH, MULHSU, MULHU)
//   - mul_state_e : controller states (IDLE, CALC, DONE)
//   - mul_sign_t  : per-operand signedness flags
//   - mul_signedness() : decodes which operands are signed for a given op
package rv32m_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } mul_state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } mul_sign_t;

  // A is signed for MULH/MULHSU, B only for MULH.
  function automatic mul_sign_t mul_signedness(input mul_op_e op);
    mul_sign_t s;
    case (op)
      OP_MULH:   begin s.a_signed = 1'b1; s.b_signed = 1'b1; end
      OP_MULHSU: begin s.a_signed = 1'b1; s.b_signed = 1'b0; end
      default:   begin s.a_signed = 1'b0; s.b_signed = 1'b0; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rv32m_mul_pp.sv
// rv32m_mul_pp -- combinational signed partial product.
//   a_i/a_ext_i : multiplicand and its extension bit, forming an (XLEN+1)-bit signed value
//   d_i/d_ext_i : B digit and its extension bit, forming a (SLICE_W+1)-bit signed value
//   pp_o        : exact signed product, XLEN+SLICE_W+2 bits wide
module rv32m_mul_pp #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input  logic [XLEN-1:0]         a_i,
  input  logic                    a_ext_i,
  input  logic [SLICE_W-1:0]      d_i,
  input  logic                    d_ext_i,
  output logic [XLEN+SLICE_W+1:0] pp_o
);
  localparam int PP_W = XLEN + SLICE_W + 2;

  logic signed [XLEN:0]    a_s;
  logic signed [SLICE_W:0] d_s;
  logic signed [PP_W-1:0]  a_x_s;
  logic signed [PP_W-1:0]  d_x_s;

  assign a_s   = {a_ext_i, a_i};
  assign d_s   = {d_ext_i, d_i};
  // Widen both factors first so the product is exact at PP_W bits.
  assign a_x_s = PP_W'(a_s);
  assign d_x_s = PP_W'(d_s);
  assign pp_o  = a_x_s * d_x_s;

endmodule

// File: rtl/rv32m_mul_iter.sv
// rv32m_mul_iter -- iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Consumes SLICE_W bits of B per cycle; N = XLEN/SLICE_W CALC cycles per op.
// Ports:
//   clk_i, rst_i (async, active-high)
//   valid_i/ready_o, op_i, op_A_i, op_B_i : request side
//   kill_i                                : flush, returns to IDLE
//   valid_o/ready_i, result_o             : result side
//   busy_o                                : controller not in IDLE
// Optional macro RV32M_MUL_EARLY_EXIT_EN: finish as soon as the remaining
// B digits are all zero (results unchanged, latency data dependent).
module rv32m_mul_iter
  import rv32m_mul_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_A_i,
  input  logic [XLEN-1:0] op_B_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int N     = XLEN / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int ACC_W = 2 * XLEN;
  localparam int PP_W  = XLEN + SLICE_W + 2;

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            a_signed_q, a_signed_d;
  logic            b_signed_q, b_signed_d;
  logic            hi_q, hi_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] result_q, result_d;

  mul_sign_t              req_sign_s;
  logic                   last_step_s;
  logic                   calc_done_s;
  logic                   a_ext_s;
  logic                   d_ext_s;
  logic [SLICE_W-1:0]     digit_s;
  logic [PP_W-1:0]        pp_s;
  logic [ACC_W-1:0]       pp_ext_s;
  logic [ACC_W-1:0]       acc_sum_s;
  logic [SH_W-1:0]        shamt_s;
  logic signed [XLEN-1:0] b_sra_s;
  logic [XLEN-1:0]        b_shift_s;

  assign req_sign_s  = mul_signedness(mul_op_e'(op_i));
  assign digit_s     = b_q[SLICE_W-1:0];
  assign last_step_s = (cnt_q == CNT_W'(N - 1));
  assign a_ext_s     = a_signed_q & a_q[XLEN-1];
  // Only the most significant digit of a signed B carries negative weight.
  assign d_ext_s     = b_signed_q & last_step_s & digit_s[SLICE_W-1];

  rv32m_mul_pp #(
    .XLEN    (XLEN),
    .SLICE_W (SLICE_W)
  ) u_pp (
    .a_i     (a_q),
    .a_ext_i (a_ext_s),
    .d_i     (digit_s),
    .d_ext_i (d_ext_s),
    .pp_o    (pp_s)
  );

  assign pp_ext_s  = ACC_W'($signed(pp_s));
  assign shamt_s   = SH_W'(cnt_q) * SH_W'(SLICE_W);
  assign acc_sum_s = acc_q + (pp_ext_s << shamt_s);
  assign b_sra_s   = $signed(b_q) >>> SLICE_W;
  assign b_shift_s = b_signed_q ? b_sra_s : (b_q >> SLICE_W);

`ifdef RV32M_MUL_EARLY_EXIT_EN
  // A signed B never reaches zero while negative, so it always runs to the signed top digit.
  assign calc_done_s = last_step_s | (b_shift_s == {XLEN{1'b0}});
`else
  assign calc_done_s = last_step_s;
`endif

  // Next-state, datapath and registered-output computation for the controller.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_signed_d = a_signed_q;
    b_signed_d = b_signed_q;
    hi_d       = hi_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (kill_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else if (valid_i && ready_q) begin
          state_d    = S_CALC;
          a_d        = op_A_i;
          b_d        = op_B_i;
          a_signed_d = req_sign_s.a_signed;
          b_signed_d = req_sign_s.b_signed;
          hi_d       = (mul_op_e'(op_i) != OP_MUL);
          acc_d      = {ACC_W{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          valid_d    = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end else begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          acc_d = acc_sum_s;
          b_d   = b_shift_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (calc_done_s) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = hi_q ? acc_sum_s[ACC_W-1:XLEN] : acc_sum_s[XLEN-1:0];
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_DONE: begin
        if (kill_i || ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      a_q        <= {XLEN{1'b0}};
      b_q        <= {XLEN{1'b0}};
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      hi_q       <= 1'b0;
      acc_q      <= {ACC_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      result_q   <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_signed_q <= a_signed_d;
      b_signed_q <= b_signed_d;
      hi_q       <= hi_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
    end
  end

  assign valid_o  = valid_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_rv32m_mul_iter.sv
// Bench for rv32m_mul_iter: two instances share the request inputs,
// dut0 with default parameters (SLICE_W=8) and dut1 with SLICE_W=1.
module tb_rv32m_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        kill = 1'b0;
  logic        ready_i = 1'b1;

  logic        ready0, valid0, busy0;
  logic [31:0] res0;
  logic        ready1, valid1, busy1;
  logic [31:0] res1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rv32m_mul_iter dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready0),
    .op_i(op_i), .op_A_i(op_a), .op_B_i(op_b), .kill_i(kill),
    .valid_o(valid0), .ready_i(ready_i), .result_o(res0), .busy_o(busy0)
  );

  rv32m_mul_iter #(.XLEN(32), .SLICE_W(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready1),
    .op_i(op_i), .op_A_i(op_a), .op_B_i(op_b), .kill_i(kill),
    .valid_o(valid1), .ready_i(ready_i), .result_o(res1), .busy_o(busy1)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected CALC-edge count for one operation.
  function automatic int calc_lat(input logic [31:0] b, input bit bs, input int sw);
    int          n;
    bit          ee;
    logic [31:0] r;
`ifdef RV32M_MUL_EARLY_EXIT_EN
    ee = 1'b1;
`else
    ee = 1'b0;
`endif
    n = 32 / sw;
    r = b;
    for (int i = 0; i < n; i++) begin
      r = bs ? 32'($signed(r) >>> sw) : (r >> sw);
      if (ee && (r == 32'h0) && (i < n - 1)) return i + 1;
    end
    return n;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!(ready0 && ready1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", {31'b0, ready0 && ready1}, 32'h1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r0, output logic [31:0] r1,
                       output int l0, output int l1);
    bit s0, s1;
    wait_idle();
    valid_i = 1'b1; op_i = op; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    // Operands must be ignored after the accept edge.
    valid_i = 1'b0; op_i = 2'b11; op_a = 32'hDEADBEEF; op_b = 32'hDEADBEEF;
    s0 = 1'b0; s1 = 1'b0; l0 = -1; l1 = -1; r0 = 32'h0; r1 = 32'h0;
    for (int k = 1; k <= 100 && !(s0 && s1); k++) begin
      @(negedge clk);
      if (!s0 && valid0) begin s0 = 1'b1; l0 = k; r0 = res0; end
      if (!s1 && valid1) begin s1 = 1'b1; l1 = k; r1 = res1; end
    end
  endtask

  initial begin
    logic [31:0] r0, r1;
    int          l0, l1;
    bit          seen;

    vecs[0]  = '{"mul_7x6",        2'b00, 32'h00000007, 32'h00000006, 32'h0000002A};
    vecs[1]  = '{"mulh_m1xm1",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[2]  = '{"mulhu_m1xm1",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{"mulhsu_m1xm1",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{"mulh_min_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5]  = '{"mul_bp_val",     2'b00, 32'h12345678, 32'h00000010, 32'h23456780};
    vecs[6]  = '{"mulh_min_max",   2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000};
    vecs[7]  = '{"mulhsu_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[8]  = '{"mul_m1xm1",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[9]  = '{"mulhu_min_x4",   2'b11, 32'h80000000, 32'h00000004, 32'h00000002};
    vecs[10] = '{"mulh_m2x3",      2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[11] = '{"mul_m2x3",       2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
    vecs[12] = '{"mul_9x3",        2'b00, 32'h00000009, 32'h00000003, 32'h0000001B};
    vecs[13] = '{"mulhsu_max_min", 2'b10, 32'h7FFFFFFF, 32'h80000000, 32'h3FFFFFFF};

    // Reset state, checked while reset is still asserted.
    rst = 1'b1;
    #3;
    check("rst_ready", {31'b0, ready0}, 32'h1);
    check("rst_valid", {31'b0, valid0}, 32'h0);
    check("rst_busy",  {31'b0, busy0},  32'h0);
    check("rst_result", res0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors: result and latency on both instances.
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r0, r1, l0, l1);
      check({vecs[i].name, "_res0"}, r0, vecs[i].exp);
      check({vecs[i].name, "_lat0"}, 32'(l0), 32'(calc_lat(vecs[i].b, vecs[i].op == 2'b01, 8)));
      check({vecs[i].name, "_res1"}, r1, vecs[i].exp);
      check({vecs[i].name, "_lat1"}, 32'(l1), 32'(calc_lat(vecs[i].b, vecs[i].op == 2'b01, 1)));
    end

    // Backpressure: result held, no accept while DONE, no same-cycle re-accept.
    wait_idle();
    ready_i = 1'b0;
    valid_i = 1'b1; op_i = 2'b00; op_a = 32'h12345678; op_b = 32'h00000010;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = valid0;
    end
    check("bp_valid_seen", {31'b0, seen}, 32'h1);
    valid_i = 1'b1; op_a = 32'h00000001; op_b = 32'h00000001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_result", res0, 32'h23456780);
      check("bp_hold_valid", {31'b0, valid0}, 32'h1);
      check("bp_hold_ready", {31'b0, ready0}, 32'h0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'b0, valid0}, 32'h0);
    check("bp_release_ready", {31'b0, ready0}, 32'h1);
    check("bp_no_reaccept",   {31'b0, busy0},  32'h0);
    valid_i = 1'b0;

    // Kill in the second CALC cycle.
    wait_idle();
    valid_i = 1'b1; op_i = 2'b00; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    check("kill_in_calc", {31'b0, busy0}, 32'h1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy",  {31'b0, busy0},  32'h0);
    check("kill_ready", {31'b0, ready0}, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (valid0) seen = 1'b1;
      @(negedge clk);
    end
    check("kill_no_valid", {31'b0, seen}, 32'h0);
    do_op(2'b00, 32'h00000003, 32'h00000005, r0, r1, l0, l1);
    check("after_kill_res0", r0, 32'h0000000F);
    check("after_kill_res1", r1, 32'h0000000F);

    // Kill together with valid in IDLE: not accepted.
    wait_idle();
    valid_i = 1'b1; kill = 1'b1; op_a = 32'h00000002; op_b = 32'h00000002;
    @(negedge clk);
    valid_i = 1'b0; kill = 1'b0;
    check("kill_idle_busy0", {31'b0, busy0}, 32'h0);
    check("kill_idle_busy1", {31'b0, busy1}, 32'h0);

    // Asynchronous reset mid-CALC.
    wait_idle();
    valid_i = 1'b1; op_i = 2'b00; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    #2;
    check("rst_mid_busy_before", {31'b0, busy0}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_ready",  {31'b0, ready0}, 32'h1);
    check("rst_mid_valid",  {31'b0, valid0}, 32'h0);
    check("rst_mid_busy",   {31'b0, busy0},  32'h0);
    check("rst_mid_result", res0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", {31'b0, ready0}, 32'h1);
    check("rst_rel_valid", {31'b0, valid0}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
